// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: program load port, redirect port and the decode-side valid/ready head.
// The slave modport is the fetch queue. The master modport is load/branch logic plus decode.
interface instr_fetch_queue_if #(
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) ();
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic               program_mem_write_en_i;
    logic [ADDR_W-1:0]  program_addr_i;
    logic [INSTR_W-1:0] program_data_i;
    logic               redirect_i;
    logic [ADDR_W-1:0]  redirect_addr_i;
    logic               ready_i;
    logic               is_valid_o;
    logic [INSTR_W-1:0] instruction_o;
    logic [ADDR_W-1:0]  program_counter_o;
    logic [CNT_W-1:0]   queue_count_o;

    modport master (
        output program_mem_write_en_i,
        output program_addr_i,
        output program_data_i,
        output redirect_i,
        output redirect_addr_i,
        output ready_i,
        input  is_valid_o,
        input  instruction_o,
        input  program_counter_o,
        input  queue_count_o
    );

    modport slave (
        input  program_mem_write_en_i,
        input  program_addr_i,
        input  program_data_i,
        input  redirect_i,
        input  redirect_addr_i,
        input  ready_i,
        output is_valid_o,
        output instruction_o,
        output program_counter_o,
        output queue_count_o
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: program RAM, free-running fetch PC and a small {pc, instruction} queue
// drained by decode. Supports redirect (flush) and a program-load mode.
module instr_fetch_queue #(
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_DEPTH  = 512,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PC_STEP    = 2
) (
    input logic               clk_i,
    input logic               reset_i,
    instr_fetch_queue_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [INSTR_W-1:0] mem [MEM_DEPTH];
    logic [INSTR_W-1:0] rdata_q;

    logic [INSTR_W-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifo_pc_q    [FIFO_DEPTH];

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic             load;
    logic             squash;
    logic             issue;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [CNT_W:0]   credit;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             unused_addr_bits;

    assign load   = bus.program_mem_write_en_i;
    assign squash = load | bus.redirect_i;

    // Credit counts the in-flight read so a returning word always has a free slot.
    assign credit = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue  = ~reset_i & ~squash & (credit < (CNT_W + 1)'(FIFO_DEPTH));
    assign push   = inflight_q & ~squash;
    assign head_valid = (count_q != '0);
    assign pop    = head_valid & bus.ready_i & ~squash;

    assign wr_idx = bus.program_addr_i[IDX_W:1];
    assign rd_idx = fetch_pc_q[IDX_W:1];

    // Byte-lane bit and address bits above the RAM size are ignored (wrap).
    assign unused_addr_bits = ^{bus.program_addr_i[ADDR_W-1:IDX_W+1],
                                bus.program_addr_i[0], bus.redirect_addr_i[0]};

    always_ff @(posedge clk_i) begin
        if (!reset_i && load) begin
            mem[wr_idx] <= bus.program_data_i;
        end
        if (issue) begin
            rdata_q <= mem[rd_idx];
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (load) begin
            fetch_pc_d = '0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else if (bus.redirect_i) begin
            fetch_pc_d = {bus.redirect_addr_i[ADDR_W-1:1], 1'b0};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
                inflight_pc_d = fetch_pc_q;
                inflight_d    = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q    <= '0;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && push) begin
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fifo_instr_q[wr_ptr_q] <= rdata_q;
        end
    end

    always_comb begin
        bus.is_valid_o        = head_valid;
        bus.queue_count_o     = count_q;
        bus.instruction_o     = '0;
        bus.program_counter_o = '0;
        if (head_valid) begin
            bus.instruction_o     = fifo_instr_q[rd_ptr_q];
            bus.program_counter_o = fifo_pc_q[rd_ptr_q];
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        count_q <= CNT_W'(FIFO_DEPTH));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push && !pop && count_q == CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based reference model.
module tb_instr_fetch_queue;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned MEM_DEPTH  = 512;
    localparam int unsigned FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_queue_if #(
        .INSTR_W   (INSTR_W),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) bus ();

    instr_fetch_queue #(
        .INSTR_W   (INSTR_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PC_STEP   (2)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: RAM image, queue of fetched pairs, one pending read.
    logic [INSTR_W-1:0] m_mem [MEM_DEPTH];
    logic [ADDR_W-1:0]  q_pc[$];
    logic [INSTR_W-1:0] q_ins[$];
    logic [ADDR_W-1:0]  m_pc;
    logic [ADDR_W-1:0]  m_inf_pc;
    bit                 m_inf;
    bit                 chk_en = 1'b0;
    bit                 do_pop;
    bit                 do_issue;

    function automatic int unsigned midx(logic [ADDR_W-1:0] a);
        return (a >> 1) % MEM_DEPTH;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            q_pc.delete();
            q_ins.delete();
            m_pc   = '0;
            m_inf  = 1'b0;
            chk_en = 1'b1;
        end else if (bus.program_mem_write_en_i) begin
            m_mem[midx(bus.program_addr_i)] = bus.program_data_i;
            q_pc.delete();
            q_ins.delete();
            m_inf = 1'b0;
            m_pc  = '0;
        end else if (bus.redirect_i) begin
            q_pc.delete();
            q_ins.delete();
            m_inf = 1'b0;
            m_pc  = bus.redirect_addr_i & ~32'd1;
        end else begin
            do_pop   = (q_pc.size() != 0) && bus.ready_i;
            do_issue = (q_pc.size() + int'(m_inf)) < FIFO_DEPTH;
            if (do_pop) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (m_inf) begin
                q_pc.push_back(m_inf_pc);
                q_ins.push_back(m_mem[midx(m_inf_pc)]);
            end
            if (do_issue) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + 32'd2;
                m_inf    = 1'b1;
            end else begin
                m_inf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", 32'(bus.is_valid_o), 32'(q_pc.size() != 0));
            chk("model_count", 32'(bus.queue_count_o), 32'(q_pc.size()));
            chk("model_pc", bus.program_counter_o, (q_pc.size() != 0) ? q_pc[0] : 32'd0);
            chk("model_instr", 32'(bus.instruction_o),
                (q_ins.size() != 0) ? 32'(q_ins[0]) : 32'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic lit(string name, bit v, logic [31:0] pc, logic [15:0] ins);
        chk({name, "_valid"}, 32'(bus.is_valid_o), 32'(v));
        chk({name, "_pc"}, bus.program_counter_o, pc);
        chk({name, "_instr"}, 32'(bus.instruction_o), 32'(ins));
    endtask

    initial begin
        reset                      = 1'b1;
        bus.program_mem_write_en_i = 1'b0;
        bus.program_addr_i         = '0;
        bus.program_data_i         = '0;
        bus.redirect_i             = 1'b0;
        bus.redirect_addr_i        = '0;
        bus.ready_i                = 1'b0;
        tick();
        tick();
        lit("reset", 1'b0, 32'd0, 16'd0);
        chk("reset_count", 32'(bus.queue_count_o), 32'd0);

        // Program load: 0x1000+i in the first words, a marker in the last word.
        reset = 1'b0;
        for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            bus.program_mem_write_en_i = 1'b1;
            bus.program_addr_i         = 32'(2 * i);
            if (i < 8)                       bus.program_data_i = 16'(32'h1000 + i);
            else if (i == int'(MEM_DEPTH) - 1) bus.program_data_i = 16'h5A5A;
            else                             bus.program_data_i = 16'($urandom);
            tick();
        end

        // Streaming after load.
        bus.program_mem_write_en_i = 1'b0;
        bus.ready_i                = 1'b1;
        tick();
        lit("first_issue", 1'b0, 32'd0, 16'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            lit("stream", 1'b1, 32'(2 * i), 16'(32'h1000 + i));
            tick();
        end

        // Backpressure: queue saturates, head held, then drains without gap.
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = 32'd0;
        bus.ready_i         = 1'b0;
        tick();
        bus.redirect_i = 1'b0;
        repeat (10) tick();
        chk("sat_count", 32'(bus.queue_count_o), 32'd4);
        lit("sat_head", 1'b1, 32'd0, 16'h1000);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lit("drain", 1'b1, 32'(2 * i), 16'(32'h1000 + i));
            tick();
        end

        // Redirect to odd address 0x9 while streaming.
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = 32'h9;
        tick();
        bus.redirect_i = 1'b0;
        lit("redir_flush", 1'b0, 32'd0, 16'd0);
        chk("redir_count", 32'(bus.queue_count_o), 32'd0);
        tick();
        tick();
        lit("redir_head", 1'b1, 32'h8, 16'h1004);
        tick();
        lit("redir_next", 1'b1, 32'hA, 16'h1005);

        // Back-to-back redirects: the last one wins.
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = 32'h4;
        tick();
        bus.redirect_addr_i = 32'hC;
        tick();
        bus.redirect_i = 1'b0;
        tick();
        tick();
        lit("b2b_head", 1'b1, 32'hC, 16'h1006);
        tick();
        lit("b2b_next", 1'b1, 32'hE, 16'h1007);

        // Reset with three queued entries and a read in flight.
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = 32'd0;
        bus.ready_i         = 1'b0;
        tick();
        bus.redirect_i = 1'b0;
        repeat (4) tick();
        chk("pre_reset_count", 32'(bus.queue_count_o), 32'd3);
        reset = 1'b1;
        tick();
        lit("mid_reset", 1'b0, 32'd0, 16'd0);
        chk("mid_reset_count", 32'(bus.queue_count_o), 32'd0);
        reset       = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        tick();
        lit("post_reset", 1'b1, 32'd0, 16'h1000);

        // RAM wrap at the MEM_DEPTH boundary.
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = 32'h3FE;
        tick();
        bus.redirect_i = 1'b0;
        tick();
        tick();
        lit("wrap_last", 1'b1, 32'h3FE, 16'h5A5A);
        tick();
        lit("wrap_first", 1'b1, 32'h400, 16'h1000);
        tick();
        lit("wrap_second", 1'b1, 32'h402, 16'h1001);

        // Random traffic checked by the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            int unsigned r;
            r                          = $urandom_range(0, 199);
            reset                      = (r == 0);
            bus.program_mem_write_en_i = (r >= 1 && r <= 6);
            bus.program_addr_i         = $urandom;
            bus.program_data_i         = 16'($urandom);
            bus.redirect_i             = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0:       bus.redirect_addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       bus.redirect_addr_i = $urandom;
                default: bus.redirect_addr_i = 32'($urandom_range(0, 2 * MEM_DEPTH));
            endcase
            bus.ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
